// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage 16-bit pipeline: opcodes, the hazard
// sequencer state encoding and common widths.
package cpu_pkg;

  localparam int REG_W = 4;
  localparam int OP_W  = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'h1;
  localparam logic [OP_W-1:0] OP_AND  = 4'h2;
  localparam logic [OP_W-1:0] OP_OR   = 4'h3;
  localparam logic [OP_W-1:0] OP_XOR  = 4'h4;
  localparam logic [OP_W-1:0] OP_SLT  = 4'h5;
  localparam logic [OP_W-1:0] OP_SW   = 4'h6;
  localparam logic [OP_W-1:0] OP_BEQ  = 4'h7;
  localparam logic [OP_W-1:0] OP_LW   = 4'h8;
  localparam logic [OP_W-1:0] OP_ADDI = 4'h9;
  localparam logic [OP_W-1:0] OP_LUI  = 4'hA;
  localparam logic [OP_W-1:0] OP_JMP  = 4'hB;
  localparam logic [OP_W-1:0] OP_CALL = 4'hC;
  localparam logic [OP_W-1:0] OP_RET  = 4'hD;
  localparam logic [OP_W-1:0] OP_HLT  = 4'hE;
  localparam logic [OP_W-1:0] OP_NOP  = 4'hF;

  localparam logic [15:0] NO_OP = 16'hF000;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2,
    ST_HALT       = 2'd3
  } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard sequencer
// (slave): decode/execute fields in, stall/flush controls and status out.
interface hazard_ctrl_if;
  import cpu_pkg::*;

  logic [OP_W-1:0]  ifid_opcode;
  logic [REG_W-1:0] ifid_rs;
  logic [REG_W-1:0] ifid_rt;
  logic             idex_mem_read;
  logic [REG_W-1:0] idex_rd;
  logic             branch_taken;
  logic             mem_busy;

  logic             hazard;
  logic             pc_write;
  logic             ifid_flush;
  logic             idex_flush;
  logic             pipe_freeze;
  logic             halted;
  logic [15:0]      stall_cycles;
  hz_state_t        dbg_state;

  modport master (
    output ifid_opcode, ifid_rs, ifid_rt, idex_mem_read, idex_rd,
           branch_taken, mem_busy,
    input  hazard, pc_write, ifid_flush, idex_flush, pipe_freeze, halted,
           stall_cycles, dbg_state
  );

  modport slave (
    input  ifid_opcode, ifid_rs, ifid_rt, idex_mem_read, idex_rd,
           branch_taken, mem_busy,
    output hazard, pc_write, ifid_flush, idex_flush, pipe_freeze, halted,
           stall_cycles, dbg_state
  );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; used for the
// stall-cycle performance count.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer: load-use bubbles, branch squashes, memory-wait
// freezes and sticky HALT, plus a saturating stall-cycle counter.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int          LOAD_STALL_CYCLES = 1,
  parameter logic [15:0] RS_USE_MASK       = 16'h03FF,
  parameter logic [15:0] RT_USE_MASK       = 16'h00FF,
  parameter logic [3:0]  HLT_OPCODE        = OP_HLT
) (
  input logic          clk,
  input logic          rst_n,
  hazard_ctrl_if.slave bus
);

  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);

  hz_state_t   state;
  hz_state_t   state_nxt;
  logic [2:0]  cnt;
  logic [2:0]  cnt_nxt;
  logic        rs_hit;
  logic        rt_hit;
  logic        load_use;
  logic        count_en;
  logic [15:0] stall_count;

  logic hz;
  logic pc_we;
  logic if_flush;
  logic ex_flush;
  logic freeze;
  logic halt_flag;

  // R0 is hardwired zero, so a load targeting it can never create a hazard.
  assign rs_hit   = RS_USE_MASK[bus.ifid_opcode] && (bus.idex_rd == bus.ifid_rs);
  assign rt_hit   = RT_USE_MASK[bus.ifid_opcode] && (bus.idex_rd == bus.ifid_rt);
  assign load_use = bus.idex_mem_read && (bus.idex_rd != '0) && (rs_hit || rt_hit);

  // A MEM_WAIT cycle with mem_busy released is evaluated exactly like RUN.
  always_comb begin
    hz        = 1'b0;
    pc_we     = 1'b1;
    if_flush  = 1'b0;
    ex_flush  = 1'b0;
    freeze    = 1'b0;
    halt_flag = 1'b0;
    state_nxt = state;
    cnt_nxt   = cnt;

    if (state == ST_HALT) begin
      halt_flag = 1'b1;
      pc_we     = 1'b0;
      hz        = 1'b1;
    end else if (bus.mem_busy) begin
      freeze    = 1'b1;
      pc_we     = 1'b0;
      state_nxt = ST_MEM_WAIT;
      cnt_nxt   = '0;
    end else if (bus.branch_taken) begin
      if_flush  = 1'b1;
      ex_flush  = 1'b1;
      state_nxt = ST_RUN;
      cnt_nxt   = '0;
    end else if (state == ST_LOAD_STALL) begin
      hz      = 1'b1;
      pc_we   = 1'b0;
      cnt_nxt = cnt - 3'd1;
      if (cnt <= 3'd1) begin
        state_nxt = ST_RUN;
        cnt_nxt   = '0;
      end
    end else if (load_use) begin
      hz    = 1'b1;
      pc_we = 1'b0;
      if (LOAD_STALL_CYCLES > 1) begin
        state_nxt = ST_LOAD_STALL;
        cnt_nxt   = STALL_RELOAD;
      end else begin
        state_nxt = ST_RUN;
      end
    end else if (bus.ifid_opcode == HLT_OPCODE) begin
      pc_we     = 1'b0;
      if_flush  = 1'b1;
      state_nxt = ST_HALT;
    end else begin
      state_nxt = ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The HALT cycles hold hazard high but are not performance stalls.
  assign count_en = (hz || freeze) && (state != ST_HALT);

  sat_counter #(.WIDTH(16)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (count_en),
    .clr   (1'b0),
    .count (stall_count)
  );

  assign bus.hazard       = hz;
  assign bus.pc_write     = pc_we;
  assign bus.ifid_flush   = if_flush;
  assign bus.idex_flush   = ex_flush;
  assign bus.pipe_freeze  = freeze;
  assign bus.halted       = halt_flag;
  assign bus.stall_cycles = stall_count;
  assign bus.dbg_state    = state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one instance with single-cycle load stalls
// and one with three-cycle load stalls, driven from the same stimulus.
module tb_hazard_ctrl;
  import cpu_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  hazard_ctrl_if a_if ();
  hazard_ctrl_if b_if ();

  hazard_ctrl #(.LOAD_STALL_CYCLES(1)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if)
  );

  hazard_ctrl #(.LOAD_STALL_CYCLES(3)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic set_in(input logic [3:0] op, input logic [3:0] rs,
                        input logic [3:0] rt, input logic mr,
                        input logic [3:0] rd, input logic br, input logic mb);
    a_if.ifid_opcode = op;  b_if.ifid_opcode = op;
    a_if.ifid_rs = rs;      b_if.ifid_rs = rs;
    a_if.ifid_rt = rt;      b_if.ifid_rt = rt;
    a_if.idex_mem_read = mr; b_if.idex_mem_read = mr;
    a_if.idex_rd = rd;      b_if.idex_rd = rd;
    a_if.branch_taken = br; b_if.branch_taken = br;
    a_if.mem_busy = mb;     b_if.mem_busy = mb;
  endtask

  task automatic idle();
    set_in(OP_ADD, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  // Inputs change 1 time unit after the edge; outputs are checked 2 later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    idle();
    #12;

    // reset state
    check("rst_state", 32'(a_if.dbg_state), 32'(ST_RUN));
    check("rst_pc_write", 32'(a_if.pc_write), 32'd1);
    check("rst_hazard", 32'(a_if.hazard), 32'd0);
    check("rst_halted", 32'(a_if.halted), 32'd0);
    check("rst_stall_cnt", 32'(a_if.stall_cycles), 32'd0);
    rst_n = 1'b1;

    // 1: single-cycle load-use on rs, then R0 and mask boundaries
    cyc(); set_in(OP_ADD, 4'd3, 4'd0, 1'b1, 4'd3, 1'b0, 1'b0); settle();
    check("lu1_hazard", 32'(a_if.hazard), 32'd1);
    check("lu1_pc_write", 32'(a_if.pc_write), 32'd0);
    cyc(); idle(); settle();
    check("lu1_hazard_off", 32'(a_if.hazard), 32'd0);
    check("lu1_pc_write_on", 32'(a_if.pc_write), 32'd1);
    check("lu1_stall_cnt", 32'(a_if.stall_cycles), 32'd1);
    cyc(); set_in(OP_ADD, 4'd0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0); settle();
    check("r0_no_hazard", 32'(a_if.hazard), 32'd0);
    check("r0_pc_write", 32'(a_if.pc_write), 32'd1);
    cyc(); set_in(OP_JMP, 4'd3, 4'd3, 1'b1, 4'd3, 1'b0, 1'b0); settle();
    check("mask_no_rs_rt", 32'(a_if.hazard), 32'd0);
    cyc(); set_in(OP_ADDI, 4'd1, 4'd3, 1'b1, 4'd3, 1'b0, 1'b0); settle();
    check("mask_rs_only", 32'(a_if.hazard), 32'd0);
    cyc(); set_in(OP_BEQ, 4'd1, 4'd3, 1'b1, 4'd3, 1'b0, 1'b0); settle();
    check("mask_rt_hit", 32'(a_if.hazard), 32'd1);
    cyc(); idle(); settle();
    check("lu1_cnt_total", 32'(a_if.stall_cycles), 32'd2);

    // 2: three-cycle stall on rt, held internally after the load leaves EX
    do_reset();
    cyc(); set_in(OP_AND, 4'd1, 4'd5, 1'b1, 4'd5, 1'b0, 1'b0); settle();
    check("lu3_c1_hazard", 32'(b_if.hazard), 32'd1);
    cyc(); idle(); settle();
    check("lu3_c2_hazard", 32'(b_if.hazard), 32'd1);
    check("lu3_c2_state", 32'(b_if.dbg_state), 32'(ST_LOAD_STALL));
    cyc(); settle();
    check("lu3_c3_hazard", 32'(b_if.hazard), 32'd1);
    check("lu3_c3_pc_write", 32'(b_if.pc_write), 32'd0);
    cyc(); settle();
    check("lu3_done_hazard", 32'(b_if.hazard), 32'd0);
    check("lu3_done_state", 32'(b_if.dbg_state), 32'(ST_RUN));
    check("lu3_stall_cnt", 32'(b_if.stall_cycles), 32'd3);

    // 2b: branch in the second stall cycle abandons the stall
    do_reset();
    cyc(); set_in(OP_AND, 4'd1, 4'd5, 1'b1, 4'd5, 1'b0, 1'b0); settle();
    check("br_c1_hazard", 32'(b_if.hazard), 32'd1);
    cyc(); set_in(OP_ADD, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0); settle();
    check("br_hazard", 32'(b_if.hazard), 32'd0);
    check("br_ifid_flush", 32'(b_if.ifid_flush), 32'd1);
    check("br_idex_flush", 32'(b_if.idex_flush), 32'd1);
    check("br_pc_write", 32'(b_if.pc_write), 32'd1);
    cyc(); idle(); settle();
    check("br_state", 32'(b_if.dbg_state), 32'(ST_RUN));
    check("br_after_hazard", 32'(b_if.hazard), 32'd0);
    check("br_stall_cnt", 32'(b_if.stall_cycles), 32'd1);

    // 3: memory wait over a load-use, then the hazard resolves after release
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(); set_in(OP_ADD, 4'd3, 4'd0, 1'b1, 4'd3, 1'b0, 1'b1); settle();
      check("mw_freeze", 32'(a_if.pipe_freeze), 32'd1);
      check("mw_pc_write", 32'(a_if.pc_write), 32'd0);
      check("mw_hazard", 32'(a_if.hazard), 32'd0);
    end
    check("mw_state", 32'(a_if.dbg_state), 32'(ST_MEM_WAIT));
    cyc(); set_in(OP_ADD, 4'd3, 4'd0, 1'b1, 4'd3, 1'b0, 1'b0); settle();
    check("mw_rel_hazard", 32'(a_if.hazard), 32'd1);
    check("mw_rel_freeze", 32'(a_if.pipe_freeze), 32'd0);
    check("mw_rel_pc_write", 32'(a_if.pc_write), 32'd0);
    cyc(); idle(); settle();
    check("mw_end_hazard", 32'(a_if.hazard), 32'd0);
    check("mw_stall_cnt", 32'(a_if.stall_cycles), 32'd5);

    // 4: HLT on the wrong path is ignored, then HLT alone halts until reset
    do_reset();
    cyc(); set_in(OP_HLT, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0); settle();
    check("hlt_br_flush", 32'(a_if.ifid_flush), 32'd1);
    check("hlt_br_idex_flush", 32'(a_if.idex_flush), 32'd1);
    check("hlt_br_pc_write", 32'(a_if.pc_write), 32'd1);
    cyc(); set_in(OP_HLT, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0); settle();
    check("hlt_in_halted", 32'(a_if.halted), 32'd0);
    check("hlt_in_pc_write", 32'(a_if.pc_write), 32'd0);
    check("hlt_in_flush", 32'(a_if.ifid_flush), 32'd1);
    cyc(); set_in(OP_ADD, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0); settle();
    check("hlt_halted", 32'(a_if.halted), 32'd1);
    check("hlt_hazard", 32'(a_if.hazard), 32'd1);
    check("hlt_br_ignored", 32'(a_if.ifid_flush), 32'd0);
    cyc(); set_in(OP_ADD, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1); settle();
    check("hlt_mb_halted", 32'(a_if.halted), 32'd1);
    check("hlt_mb_ignored", 32'(a_if.pipe_freeze), 32'd0);
    cyc(); idle(); settle();
    check("hlt_sticky", 32'(a_if.halted), 32'd1);
    check("hlt_no_count", 32'(a_if.stall_cycles), 32'd0);
    do_reset();
    #1;
    check("hlt_rst_halted", 32'(a_if.halted), 32'd0);
    check("hlt_rst_state", 32'(a_if.dbg_state), 32'(ST_RUN));

    // 6: asynchronous reset in the middle of a load stall
    do_reset();
    cyc(); set_in(OP_AND, 4'd1, 4'd5, 1'b1, 4'd5, 1'b0, 1'b0); settle();
    cyc(); idle(); settle();
    check("ar_pre_state", 32'(b_if.dbg_state), 32'(ST_LOAD_STALL));
    check("ar_pre_cnt", 32'(b_if.stall_cycles), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("ar_hazard", 32'(b_if.hazard), 32'd0);
    check("ar_pc_write", 32'(b_if.pc_write), 32'd1);
    check("ar_state", 32'(b_if.dbg_state), 32'(ST_RUN));
    check("ar_stall_cnt", 32'(b_if.stall_cycles), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 5: saturation of the stall counter under a long memory wait
    do_reset();
    cyc(); set_in(OP_ADD, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    repeat (65534) cyc();
    settle();
    check("sat_below", 32'(a_if.stall_cycles), 32'h0000FFFE);
    cyc(); settle();
    check("sat_reach", 32'(a_if.stall_cycles), 32'h0000FFFF);
    repeat (5) cyc();
    settle();
    check("sat_hold", 32'(a_if.stall_cycles), 32'h0000FFFF);
    check("sat_freeze", 32'(a_if.pipe_freeze), 32'd1);
    cyc(); idle();
    cyc(); settle();
    check("sat_after", 32'(a_if.stall_cycles), 32'h0000FFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
